// File: rtl/pwm_fade_multi.sv
// Multi-channel PWM fader: each trigger restarts a channel at full brightness, holds, then fades linearly to off.
// Define PWM_FADE_GAMMA_EN to square the level (gamma 2.0) before PWM comparison.
module pwm_fade_multi #(
    parameter int CHANNELS    = 4,
    parameter int LEVEL_BITS  = 8,
    parameter int FADE_BITS   = 24,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] trigger,
    output logic [CHANNELS-1:0] drive,
    output logic [CHANNELS-1:0] active
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FADE = 2'd2
    } state_t;

    logic [LEVEL_BITS-1:0] pwm_cnt;
    state_t                state_q [CHANNELS];
    state_t                state_d [CHANNELS];
    logic [FADE_BITS-1:0]  fade_q  [CHANNELS];
    logic [FADE_BITS-1:0]  fade_d  [CHANNELS];
    logic [HOLD_W-1:0]     hold_q  [CHANNELS];
    logic [HOLD_W-1:0]     hold_d  [CHANNELS];
    logic [CHANNELS-1:0]   drive_d;
    logic [CHANNELS-1:0]   active_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            drive   <= '0;
            active  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                fade_q[i]  <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            drive   <= drive_d;
            active  <= active_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                fade_q[i]  <= fade_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    // A trigger overrides whatever the channel was doing, including an ongoing hold.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            fade_d[i]  = fade_q[i];
            hold_d[i]  = hold_q[i];
            if (trigger[i]) begin
                fade_d[i]  = '1;
                hold_d[i]  = HOLD_LOAD;
                state_d[i] = (HOLD_CYCLES > 0) ? HOLD : FADE;
            end else begin
                case (state_q[i])
                    IDLE: fade_d[i] = '0;
                    HOLD: begin
                        fade_d[i] = '1;
                        if (hold_q[i] == '0) begin
                            state_d[i] = FADE;
                        end else begin
                            hold_d[i] = hold_q[i] - 1'b1;
                        end
                    end
                    FADE: begin
                        fade_d[i] = fade_q[i] - 1'b1;
                        if (fade_q[i] <= FADE_BITS'(1)) begin
                            state_d[i] = IDLE;
                            fade_d[i]  = '0;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        fade_d[i]  = '0;
                        hold_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    // Outputs are computed from current state and registered, so they lag the counters by one cycle.
    always_comb begin
        logic [LEVEL_BITS-1:0]   level;
        logic [LEVEL_BITS-1:0]   eff_level;
`ifdef PWM_FADE_GAMMA_EN
        logic [2*LEVEL_BITS-1:0] level_sq;
`endif
        drive_d  = '0;
        active_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            level = fade_q[i][FADE_BITS-1 -: LEVEL_BITS];
`ifdef PWM_FADE_GAMMA_EN
            level_sq  = level * level;
            eff_level = level_sq[2*LEVEL_BITS-1 -: LEVEL_BITS];
`else
            eff_level = level;
`endif
            drive_d[i]  = (&level) ? 1'b1 : (pwm_cnt < eff_level);
            active_d[i] = (state_q[i] != IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_fade_multi.sv
// Scoreboard bench for pwm_fade_multi: a time-since-trigger model predicts drive/active each cycle.
module tb_pwm_fade_multi;

    localparam int CH      = 4;
    localparam int HC      = 3;
    localparam int ACT_LEN = HC + 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] trigger = '0;
    logic [CH-1:0] drive;
    logic [CH-1:0] active;

    int            errors = 0;
    int            checks = 0;
    logic [7:0]    sb[$];
    logic [7:0]    exp_v;
    int            t_m[CH];
    int            pwm_m;
    int            n_act;

    pwm_fade_multi #(
        .CHANNELS(CH), .LEVEL_BITS(4), .FADE_BITS(8), .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .drive(drive), .active(active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_fade(int c);
        if (t_m[c] >= ACT_LEN) return 8'h00;
        if (t_m[c] < HC) return 8'hFF;
        return 8'(255 - (t_m[c] - HC));
    endfunction

    function automatic logic [7:0] model_out();
        logic [7:0] r;
        logic [7:0] f;
        logic [3:0] lvl;
        logic [3:0] eff;
        logic [7:0] sq;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            f   = model_fade(c);
            lvl = f[7:4];
            sq  = lvl * lvl;
`ifdef PWM_FADE_GAMMA_EN
            eff = sq[7:4];
`else
            eff = lvl;
`endif
            r[4+c] = (lvl == 4'hF) ? 1'b1 : (pwm_m < int'(eff));
            r[c]   = (t_m[c] < ACT_LEN);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) t_m[c] = ACT_LEN;
        pwm_m = 0;
        sb.delete();
    endtask

    // Expected outputs for the next edge are queued from the pre-edge model state.
    task automatic tick();
        sb.push_back(model_out());
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            if (trigger[c]) t_m[c] = 0;
            else if (t_m[c] < ACT_LEN) t_m[c]++;
        end
        pwm_m = (pwm_m + 1) % 16;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        trigger = '0;
        model_reset();
        #2;
        checks++;
        if ({drive, active} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b expected 00000000", {drive, active});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            exp_v = sb.pop_front();
            checks++;
            if ({drive, active} !== exp_v) begin
                errors++;
                $display("[TB] FAIL idle_cycle %0d got %b expected %b", k, {drive, active}, exp_v);
            end
        end
        checks++;
        if (dut.pwm_cnt !== 4'(pwm_m)) begin
            errors++;
            $display("[TB] FAIL pwm_wrap got %0d expected %0d", dut.pwm_cnt, pwm_m);
        end
    endtask

    task automatic test_single_fade();
        n_act = 0;
        trigger = 4'b0001;
        for (int k = 0; k < 266; k++) begin
            tick();
            trigger = '0;
            exp_v = sb.pop_front();
            checks++;
            if ({drive, active} !== exp_v) begin
                errors++;
                $display("[TB] FAIL single_fade cycle %0d got %b expected %b", k, {drive, active}, exp_v);
            end
            if (active[0]) n_act++;
        end
        checks++;
        if (n_act !== ACT_LEN) begin
            errors++;
            $display("[TB] FAIL single_active_len got %0d expected %0d", n_act, ACT_LEN);
        end
    endtask

    task automatic test_retrigger();
        trigger = 4'b0010;
        for (int k = 0; k < 300 && model_fade(1) != 8'h40; k++) begin
            tick();
            trigger = '0;
            exp_v = sb.pop_front();
            checks++;
            if ({drive, active} !== exp_v) begin
                errors++;
                $display("[TB] FAIL retrig_fade cycle %0d got %b expected %b", k, {drive, active}, exp_v);
            end
        end
        checks++;
        if (model_fade(1) != 8'h40) begin
            errors++;
            $display("[TB] FAIL retrig_wait timeout got %h expected 40", model_fade(1));
        end
        trigger = 4'b0010;
        tick();
        trigger = '0;
        exp_v = sb.pop_front();
        checks++;
        if ({drive, active} !== exp_v) begin
            errors++;
            $display("[TB] FAIL retrig_edge got %b expected %b", {drive, active}, exp_v);
        end
        checks++;
        if (dut.fade_q[1] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL retrig_reload got %h expected ff", dut.fade_q[1]);
        end
        n_act = 0;
        for (int k = 0; k < 265; k++) begin
            tick();
            exp_v = sb.pop_front();
            checks++;
            if ({drive, active} !== exp_v) begin
                errors++;
                $display("[TB] FAIL retrig_tail cycle %0d got %b expected %b", k, {drive, active}, exp_v);
            end
            if (active[1]) n_act++;
        end
        checks++;
        if (n_act !== ACT_LEN) begin
            errors++;
            $display("[TB] FAIL retrig_active_len got %0d expected %0d", n_act, ACT_LEN);
        end
    endtask

    task automatic test_simultaneous();
        trigger = 4'b1111;
        for (int k = 0; k < 286; k++) begin
            tick();
            trigger = (k < 20) ? 4'b0100 : 4'b0000;
            exp_v = sb.pop_front();
            checks++;
            if ({drive, active} !== exp_v) begin
                errors++;
                $display("[TB] FAIL simul cycle %0d got %b expected %b", k, {drive, active}, exp_v);
            end
        end
        checks++;
        if (active !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL simul_end_active got %b expected 0000", active);
        end
    endtask

    task automatic test_async_reset();
        trigger = 4'b1000;
        for (int k = 0; k < 51; k++) begin
            tick();
            trigger = '0;
            exp_v = sb.pop_front();
            checks++;
            if ({drive, active} !== exp_v) begin
                errors++;
                $display("[TB] FAIL pre_reset cycle %0d got %b expected %b", k, {drive, active}, exp_v);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({drive, active} !== 8'h00 || dut.pwm_cnt !== 4'h0 || dut.fade_q[3] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset got out=%b pwm=%0d fade3=%h expected all zero",
                     {drive, active}, dut.pwm_cnt, dut.fade_q[3]);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        trigger = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            trigger = '0;
            exp_v = sb.pop_front();
            checks++;
            if ({drive, active} !== exp_v) begin
                errors++;
                $display("[TB] FAIL post_reset cycle %0d got %b expected %b", k, {drive, active}, exp_v);
            end
        end
        checks++;
        if (active !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL first_trigger_accept got %b expected 0001", active);
        end
    endtask

    initial begin
        test_reset();
        test_single_fade();
        test_retrigger();
        test_simultaneous();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
